// File: rtl/stopwatch_ctrl_if.sv
// Control/display bundle between the stopwatch sequencer and its neighbours.
// Optional countdown signals appear only when STOPWATCH_COUNTDOWN_EN is defined.
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause;
  logic       adj;
  logic       sel;
  logic [2:0] min1;
  logic [3:0] min2;
  logic [2:0] sec1;
  logic [3:0] sec2;
  logic       blink;
  logic       running;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic       down;
  logic       done;
`endif

  modport master (
    output tick_1hz, tick_2hz, pause, adj, sel,
    input  min1, min2, sec1, sec2, blink, running
`ifdef STOPWATCH_COUNTDOWN_EN
    , output down
    , input  done
`endif
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause, adj, sel,
    output min1, min2, sec1, sec2, blink, running
`ifdef STOPWATCH_COUNTDOWN_EN
    , input  down
    , output done
`endif
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: MM:SS BCD time registers plus run/pause/adjust FSM.
// Optional countdown mode is enabled by defining STOPWATCH_COUNTDOWN_EN.
module stopwatch_ctrl (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] min1_r, min1_s, sec1_r, sec1_s;
  logic [3:0] min2_r, min2_s, sec2_r, sec2_s;
  logic       blink_r, blink_s;
  logic       running_r;
  logic       done_r, done_s;
  logic       run_tick_s, adj_tick_s, zero_s;
  logic [4:0] s2_inc_s, m2_inc_s;
  logic [3:0] s1_inc_s, m1_inc_s;

  // Returns {carry, digit}; out-of-range digits collapse to 0 without carry.
  function automatic logic [4:0] unit_inc(input logic [3:0] d);
    if (d == 4'd9)     return {1'b1, 4'd0};
    else if (d > 4'd9) return {1'b0, 4'd0};
    else               return {1'b0, d + 4'd1};
  endfunction

  function automatic logic [3:0] tens_inc(input logic [2:0] d);
    if (d == 3'd5)     return {1'b1, 3'd0};
    else if (d > 3'd5) return {1'b0, 3'd0};
    else               return {1'b0, d + 3'd1};
  endfunction

`ifdef STOPWATCH_COUNTDOWN_EN
  logic [4:0] s2_dec_s, m2_dec_s;
  logic [3:0] s1_dec_s, m1_dec_s;

  function automatic logic [4:0] unit_dec(input logic [3:0] d);
    if (d == 4'd0)     return {1'b1, 4'd9};
    else if (d > 4'd9) return {1'b0, 4'd0};
    else               return {1'b0, d - 4'd1};
  endfunction

  function automatic logic [3:0] tens_dec(input logic [2:0] d);
    if (d == 3'd0)     return {1'b1, 3'd5};
    else if (d > 3'd5) return {1'b0, 3'd0};
    else               return {1'b0, d - 3'd1};
  endfunction
`endif

  // Next-state, time-digit and blink logic.
  always_comb begin
    state_s    = state_r;
    min1_s     = min1_r;
    min2_s     = min2_r;
    sec1_s     = sec1_r;
    sec2_s     = sec2_r;
    blink_s    = 1'b0;
    done_s     = 1'b0;
    zero_s     = ({min1_r, min2_r, sec1_r, sec2_r} == 14'd0);
    run_tick_s = (state_r == RUN) && !sw.adj && sw.tick_1hz;
    adj_tick_s = (state_r == ADJUST) && sw.adj && sw.tick_2hz;
    s2_inc_s   = unit_inc(sec2_r);
    s1_inc_s   = tens_inc(sec1_r);
    m2_inc_s   = unit_inc(min2_r);
    m1_inc_s   = tens_inc(min1_r);

    if (sw.adj) begin
      state_s = ADJUST;
    end else if (state_r == ADJUST) begin
      state_s = PAUSED;
    end else if (sw.pause) begin
      case (state_r)
        RUN:     state_s = PAUSED;
`ifdef STOPWATCH_COUNTDOWN_EN
        PAUSED:  state_s = (sw.down && zero_s) ? PAUSED : RUN;
`else
        PAUSED:  state_s = RUN;
`endif
        default: state_s = PAUSED;
      endcase
    end else begin
      state_s = state_r;
    end

`ifdef STOPWATCH_COUNTDOWN_EN
    s2_dec_s = unit_dec(sec2_r);
    s1_dec_s = tens_dec(sec1_r);
    m2_dec_s = unit_dec(min2_r);
    m1_dec_s = tens_dec(min1_r);
    if (run_tick_s && sw.down) begin
      // Borrow chain; a count already at 00:00 holds without pulsing done.
      if (!zero_s) begin
        sec2_s = s2_dec_s[3:0];
        sec1_s = s2_dec_s[4] ? s1_dec_s[2:0] : sec1_r;
        min2_s = (s2_dec_s[4] && s1_dec_s[3]) ? m2_dec_s[3:0] : min2_r;
        min1_s = (s2_dec_s[4] && s1_dec_s[3] && m2_dec_s[4]) ? m1_dec_s[2:0] : min1_r;
        if ({min1_s, min2_s, sec1_s, sec2_s} == 14'd0) begin
          done_s  = 1'b1;
          state_s = PAUSED;
        end else begin
          done_s  = 1'b0;
        end
      end else begin
        done_s = 1'b0;
      end
    end else
`endif
    if (run_tick_s) begin
      sec2_s = s2_inc_s[3:0];
      sec1_s = s2_inc_s[4] ? s1_inc_s[2:0] : sec1_r;
      min2_s = (s2_inc_s[4] && s1_inc_s[3]) ? m2_inc_s[3:0] : min2_r;
      min1_s = (s2_inc_s[4] && s1_inc_s[3] && m2_inc_s[4]) ? m1_inc_s[2:0] : min1_r;
    end else if (adj_tick_s && sw.sel) begin
      sec2_s = s2_inc_s[3:0];
      sec1_s = s2_inc_s[4] ? s1_inc_s[2:0] : sec1_r;
    end else if (adj_tick_s) begin
      min2_s = m2_inc_s[3:0];
      min1_s = m2_inc_s[4] ? m1_inc_s[2:0] : min1_r;
    end else begin
      sec2_s = sec2_r;
    end

    if (state_s == ADJUST) begin
      if (state_r != ADJUST) blink_s = 1'b0;
      else if (sw.tick_2hz)  blink_s = ~blink_r;
      else                   blink_s = blink_r;
    end else begin
      blink_s = 1'b0;
    end
  end

  // Registered state and outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= PAUSED;
      min1_r    <= 3'd0;
      min2_r    <= 4'd0;
      sec1_r    <= 3'd0;
      sec2_r    <= 4'd0;
      blink_r   <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      min1_r    <= min1_s;
      min2_r    <= min2_s;
      sec1_r    <= sec1_s;
      sec2_r    <= sec2_s;
      blink_r   <= blink_s;
      running_r <= (state_s == RUN);
      done_r    <= done_s;
    end
  end

  assign sw.min1    = min1_r;
  assign sw.min2    = min2_r;
  assign sw.sec1    = sec1_r;
  assign sw.sec2    = sec2_r;
  assign sw.blink   = blink_r;
  assign sw.running = running_r;
`ifdef STOPWATCH_COUNTDOWN_EN
  assign sw.done    = done_r;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// stimulus against a seconds/minutes arithmetic reference model.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  stopwatch_ctrl_if sw ();
  stopwatch_ctrl dut (.clk(clk), .reset(reset), .sw(sw));

  always #5 clk = ~clk;

  localparam int M_PAUSED = 0;
  localparam int M_RUN    = 1;
  localparam int M_ADJ    = 2;

  int mins, secs, mode;
  bit mblink, mdone;
  bit a_lvl, s_lvl, dn_lvl;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_min1"}, {1'b0, sw.min1}, 4'(mins / 10));
    chk({tag, "_min2"}, sw.min2, 4'(mins % 10));
    chk({tag, "_sec1"}, {1'b0, sw.sec1}, 4'(secs / 10));
    chk({tag, "_sec2"}, sw.sec2, 4'(secs % 10));
    chk({tag, "_blink"}, {3'd0, sw.blink}, {3'd0, mblink});
    chk({tag, "_running"}, {3'd0, sw.running}, {3'd0, (mode == M_RUN)});
`ifdef STOPWATCH_COUNTDOWN_EN
    chk({tag, "_done"}, {3'd0, sw.done}, {3'd0, mdone});
`endif
  endtask

  // Reference: time held as total seconds / field values, updated per clock.
  task automatic model_step(input bit r, input bit t1, input bit t2, input bit p);
    int tot;
    mdone = 1'b0;
    if (r) begin
      mins = 0; secs = 0; mode = M_PAUSED; mblink = 1'b0;
    end else begin
      tot = mins * 60 + secs;
      if (mode == M_RUN && !a_lvl && t1) begin
        if (dn_lvl) begin
          if (tot > 0) begin
            tot = tot - 1;
            mdone = (tot == 0);
          end
        end else begin
          tot = (tot + 1) % 3600;
        end
        mins = tot / 60;
        secs = tot % 60;
      end
      if (mode == M_ADJ && a_lvl && t2) begin
        if (s_lvl) secs = (secs + 1) % 60;
        else       mins = (mins + 1) % 60;
      end
      if (!a_lvl)              mblink = 1'b0;
      else if (mode != M_ADJ)  mblink = 1'b0;
      else if (t2)             mblink = ~mblink;
      if (a_lvl)               mode = M_ADJ;
      else if (mode == M_ADJ)  mode = M_PAUSED;
      else if (mdone)          mode = M_PAUSED;
      else if (p) begin
        if (mode == M_RUN)                            mode = M_PAUSED;
        else if (dn_lvl && mins == 0 && secs == 0)    mode = M_PAUSED;
        else                                          mode = M_RUN;
      end
    end
  endtask

  task automatic cycle(input string tag, input bit r, input bit t1, input bit t2, input bit p);
    reset       = r;
    sw.tick_1hz = t1;
    sw.tick_2hz = t2;
    sw.pause    = p;
    sw.adj      = a_lvl;
    sw.sel      = s_lvl;
`ifdef STOPWATCH_COUNTDOWN_EN
    sw.down     = dn_lvl;
`else
    dn_lvl      = 1'b0;
`endif
    model_step(r, t1, t2, p);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    a_lvl = 1'b0; s_lvl = 1'b0; dn_lvl = 1'b0;
    mins = 0; secs = 0; mode = M_PAUSED; mblink = 1'b0; mdone = 1'b0;

    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_sec2", sw.sec2, 4'd0);

    // Run and count 61 seconds.
    cycle("start", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 61; i++) begin
      cycle("count", 1'b0, 1'b1, 1'b0, 1'b0);
      cycle("gap", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("c61_min2", sw.min2, 4'd1);
    chk("c61_sec2", sw.sec2, 4'd1);
    chk("c61_run", {3'd0, sw.running}, 4'd1);

    // Preload 59:59 through adjust, then wrap.
    cycle("reset2", 1'b1, 1'b0, 1'b0, 1'b0);
    a_lvl = 1'b1; s_lvl = 1'b0;
    cycle("adj_enter", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 59; i++) cycle("adj_min", 1'b0, 1'b0, 1'b1, 1'b0);
    s_lvl = 1'b1;
    for (int i = 0; i < 59; i++) cycle("adj_sec", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pre_min1", {1'b0, sw.min1}, 4'd5);
    chk("pre_sec2", sw.sec2, 4'd9);
    a_lvl = 1'b0;
    cycle("adj_exit", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("run", 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("wrap", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_min1", {1'b0, sw.min1}, 4'd0);
    chk("wrap_sec1", {1'b0, sw.sec1}, 4'd0);

    // Pause and tick together at 00:05.
    cycle("reset3", 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("run3", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle("to5", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("pause_tick", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pt_sec2", sw.sec2, 4'd6);
    chk("pt_run", {3'd0, sw.running}, 4'd0);
    cycle("paused_tick", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ptk_sec2", sw.sec2, 4'd6);

    // Seconds adjust wrap with blink sequence.
    cycle("reset4", 1'b1, 1'b0, 1'b0, 1'b0);
    a_lvl = 1'b1; s_lvl = 1'b1;
    cycle("adj4", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 58; i++) cycle("to58", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b58", {3'd0, sw.blink}, 4'd0);
    cycle("b59", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b59_blink", {3'd0, sw.blink}, 4'd1);
    cycle("b00", 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("b01", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("b01_sec2", sw.sec2, 4'd1);
    chk("b01_min2", sw.min2, 4'd0);
    chk("b01_blink", {3'd0, sw.blink}, 4'd1);
    a_lvl = 1'b0;
    cycle("drop_adj", 1'b0, 1'b0, 1'b1, 1'b0);
    a_lvl = 1'b1; s_lvl = 1'b0;
    cycle("readj", 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("readj_t", 1'b0, 1'b0, 1'b1, 1'b0);
    a_lvl = 1'b0;
    cycle("mid_reset", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("mr_min2", sw.min2, 4'd0);

`ifdef STOPWATCH_COUNTDOWN_EN
    a_lvl = 1'b1; s_lvl = 1'b1;
    cycle("cd_adj", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("cd_s1", 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("cd_s2", 1'b0, 1'b0, 1'b1, 1'b0);
    a_lvl = 1'b0; dn_lvl = 1'b1;
    cycle("cd_exit", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("cd_run", 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("cd_t1", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("cd_t2", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cd_done", {3'd0, sw.done}, 4'd1);
    chk("cd_run0", {3'd0, sw.running}, 4'd0);
    cycle("cd_t3", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("cd_done_off", {3'd0, sw.done}, 4'd0);
    cycle("cd_p0", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cd_p0_run", {3'd0, sw.running}, 4'd0);
    dn_lvl = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(0, 7) == 0)  s_lvl = ~s_lvl;
`ifdef STOPWATCH_COUNTDOWN_EN
      if ($urandom_range(0, 49) == 0) dn_lvl = ~dn_lvl;
`endif
      cycle("rnd", ($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
